// File: rtl/fc_ifmap_rd_ctrl.sv
// fc_ifmap_rd_ctrl: read-side sequencer for the FC ifmap buffer.
// Issues buffer reads (rden_o/rdptr_o) and streams the returned bytes to the
// FC PE array over valid/ready. It replays the stored vector rpt+1 times.
// Read data lands in a 2-entry skid FIFO whose head is the stream output.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start_i             job start, sampled only in IDLE
//   len_i, rpt_i        vector length (0..2**ADDR_W) and extra passes, latched on start
//   rden_o, rdptr_o     buffer read port; rdptr_o holds its last value when idle
//   ifmap_i             buffer read data, valid the cycle after rden_o
//   ifmap_o, valid_o,
//   ready_i, last_o     output stream; last_o marks the final element of a pass
//   done_o              one-cycle completion pulse
//   busy_o              job in progress
//   stall_cnt_o         (FC_RD_STALL_CNT_EN only) valid-without-ready cycle count
//
// Optional feature macro: FC_RD_STALL_CNT_EN
module fc_ifmap_rd_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [7:0]        rpt_i,
    output logic              rden_o,
    output logic [ADDR_W-1:0] rdptr_o,
    input  logic [DATA_W-1:0] ifmap_i,
    output logic [DATA_W-1:0] ifmap_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic              done_o,
`ifdef FC_RD_STALL_CNT_EN
    output logic [15:0]       stall_cnt_o,
`endif
    output logic              busy_o
);

    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state_q, state_d;

    logic [ADDR_W:0]   len_q;
    logic [7:0]        rpt_q;
    logic [ADDR_W:0]   rd_idx_q;
    logic [7:0]        rd_pass_q;
    logic              rd_rem_q;
    logic [ADDR_W-1:0] rdptr_q;
    logic              inflight_q, inf_last_q, inf_final_q;
    logic [1:0]        count_q;
    logic [DATA_W-1:0] head_data_q, skid_data_q;
    logic              head_last_q, head_final_q, skid_last_q, skid_final_q;
    logic              busy_q;

    logic       pop, push, rden, start_acc, iss_last, iss_final;
    logic [2:0] occ;

    assign valid_o   = (count_q != 2'd0);
    assign pop       = valid_o & ready_i;
    assign push      = inflight_q;
    assign iss_last  = (rd_idx_q == len_q - LEN_ONE);
    assign iss_final = iss_last && (rd_pass_q == rpt_q);
    // Occupancy after this cycle's pop, including the read already in flight.
    assign occ       = 3'(count_q) + 3'(inflight_q) - 3'(pop);

    assign rden_o  = rden;
    assign rdptr_o = rden ? rd_idx_q[ADDR_W-1:0] : rdptr_q;
    assign ifmap_o = head_data_q;
    assign last_o  = valid_o & head_last_q;
    assign done_o  = (state_q == FIN);
    assign busy_o  = busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        rden      = 1'b0;
        start_acc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        start_acc = 1'b1;
                        state_d   = RUN;
                    end else begin
                        state_d   = FIN;
                    end
                end
            end
            RUN: begin
                rden = rd_rem_q && (occ < 3'd2);
                if (pop && head_final_q) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q        <= '0;
            rpt_q        <= '0;
            rd_idx_q     <= '0;
            rd_pass_q    <= '0;
            rd_rem_q     <= 1'b0;
            rdptr_q      <= '0;
            inflight_q   <= 1'b0;
            inf_last_q   <= 1'b0;
            inf_final_q  <= 1'b0;
            count_q      <= '0;
            head_data_q  <= '0;
            head_last_q  <= 1'b0;
            head_final_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_final_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            inflight_q  <= rden;
            inf_last_q  <= iss_last;
            inf_final_q <= iss_final;

            if (start_acc) begin
                len_q     <= len_i;
                rpt_q     <= rpt_i;
                rd_idx_q  <= '0;
                rd_pass_q <= '0;
                rd_rem_q  <= 1'b1;
                busy_q    <= 1'b1;
            end else if (state_q == FIN) begin
                busy_q    <= 1'b0;
            end

            if (rden) begin
                rdptr_q <= rd_idx_q[ADDR_W-1:0];
                if (iss_last) begin
                    rd_idx_q <= '0;
                    if (iss_final) rd_rem_q  <= 1'b0;
                    else           rd_pass_q <= rd_pass_q + 8'd1;
                end else begin
                    rd_idx_q <= rd_idx_q + LEN_ONE;
                end
            end

            // Head register doubles as the output stage; the skid slot only
            // fills when the head is stalled and a read was already in flight.
            unique case (count_q)
                2'd0: begin
                    if (push) begin
                        head_data_q  <= ifmap_i;
                        head_last_q  <= inf_last_q;
                        head_final_q <= inf_final_q;
                        count_q      <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_data_q  <= ifmap_i;
                        head_last_q  <= inf_last_q;
                        head_final_q <= inf_final_q;
                    end else if (pop) begin
                        count_q      <= 2'd0;
                    end else if (push) begin
                        skid_data_q  <= ifmap_i;
                        skid_last_q  <= inf_last_q;
                        skid_final_q <= inf_final_q;
                        count_q      <= 2'd2;
                    end
                end
                default: begin
                    if (pop) begin
                        head_data_q  <= skid_data_q;
                        head_last_q  <= skid_last_q;
                        head_final_q <= skid_final_q;
                        if (push) begin
                            skid_data_q  <= ifmap_i;
                            skid_last_q  <= inf_last_q;
                            skid_final_q <= inf_final_q;
                        end else begin
                            count_q <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef FC_RD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (state_q == IDLE && start_i) begin
            stall_cnt_o <= '0;
        end else if (valid_o && !ready_i && stall_cnt_o != '1) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fc_ifmap_rd_ctrl.sv
module tb_fc_ifmap_rd_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    localparam int M_HI     = 0;
    localparam int M_RAND   = 1;
    localparam int M_TOG    = 2;
    localparam int M_STALL7 = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [ADDR_W:0]   len_i;
    logic [7:0]        rpt_i;
    logic              rden_o;
    logic [ADDR_W-1:0] rdptr_o;
    logic [DATA_W-1:0] ifmap_i;
    logic [DATA_W-1:0] ifmap_o;
    logic              valid_o;
    logic              ready_i;
    logic              last_o;
    logic              done_o;
    logic              busy_o;
`ifdef FC_RD_STALL_CNT_EN
    logic [15:0]       stall_cnt_o;
`endif

    fc_ifmap_rd_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .len_i   (len_i),
        .rpt_i   (rpt_i),
        .rden_o  (rden_o),
        .rdptr_o (rdptr_o),
        .ifmap_i (ifmap_i),
        .ifmap_o (ifmap_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .last_o  (last_o),
        .done_o  (done_o),
`ifdef FC_RD_STALL_CNT_EN
        .stall_cnt_o (stall_cnt_o),
`endif
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    // Synchronous-read buffer model feeding the read port.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) if (rden_o) ifmap_i <= mem[rdptr_o];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        int len;
        int rpt;
        int mode;
        bit hold;
        int exp_outs;
        int exp_lasts;
        int exp_done;
    } vec_t;

    // One job: the reference is the flat list of (data,last) the job must
    // produce, built from the buffer contents and len/rpt with plain loops.
    task automatic run_job(input string tag, input int len, input int rpt, input int mode,
                           input bit hold, input int exp_outs, input int exp_lasts,
                           input int exp_done);
        logic [DATA_W:0] exp_q[$];
        logic [DATA_W:0] e;
        int addr_q[$];
        int a, cyc, budget, outstanding, stall7;
        int outs, lasts, dones, done_cyc, first_rden, first_valid;
        int data_bad, addr_bad, extra_rd, credit_bad, unstable, busy_bad, post_bad;
        bit prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic prev_last;

        outs = 0; lasts = 0; dones = 0; done_cyc = -1; first_rden = -1; first_valid = -1;
        data_bad = 0; addr_bad = 0; extra_rd = 0; credit_bad = 0; unstable = 0;
        busy_bad = 0; post_bad = 0; outstanding = 0; stall7 = 0;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;

        for (int p = 0; p <= rpt; p++)
            for (int i = 0; i < len; i++) begin
                exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, mem[i]});
                addr_q.push_back(i);
            end
        budget = len * (rpt + 1) * 6 + 40;

        @(posedge clk); #1;
        start_i = 1'b1;
        len_i   = (ADDR_W+1)'(len);
        rpt_i   = 8'(rpt);
        ready_i = 1'b1;
        cyc = 0;
        @(negedge clk);

        while (done_cyc < 0 && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (hold) begin
                start_i = 1'b1;
                len_i   = (ADDR_W+1)'(len + 3);
            end else begin
                start_i = 1'b0;
            end
            case (mode)
                M_RAND:  ready_i = ($urandom_range(0, 99) < 55);
                M_TOG:   ready_i = (cyc % 2 == 0) && ($urandom_range(0, 3) != 0);
                M_STALL7: begin
                    if (valid_o && stall7 < 7) begin
                        ready_i = 1'b0;
                        stall7++;
                    end else begin
                        ready_i = 1'b1;
                    end
                end
                default: ready_i = 1'b1;
            endcase
            @(negedge clk);

            if (rden_o) begin
                if (first_rden < 0) first_rden = cyc;
                if (addr_q.size() == 0) extra_rd++;
                else begin
                    a = addr_q.pop_front();
                    if (int'(rdptr_o) != a) addr_bad++;
                end
                if (outstanding - ((valid_o && ready_i) ? 1 : 0) >= 2) credit_bad++;
            end
            if (prev_stall && (!valid_o || ifmap_o != prev_data || last_o != prev_last))
                unstable++;
            if (valid_o && first_valid < 0) first_valid = cyc;
            if (valid_o && ready_i) begin
                outs++;
                if (last_o) lasts++;
                if (exp_q.size() == 0) data_bad++;
                else begin
                    e = exp_q.pop_front();
                    if ({last_o, ifmap_o} != e) data_bad++;
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_data  = ifmap_o;
            prev_last  = last_o;
            outstanding = outstanding + (rden_o ? 1 : 0) - ((valid_o && ready_i) ? 1 : 0);
            if (len != 0 && !done_o && !busy_o) busy_bad++;
            if (len == 0 && busy_o) busy_bad++;
            if (done_o) begin
                dones++;
                done_cyc = cyc;
            end
        end

`ifdef FC_RD_STALL_CNT_EN
        if (mode == M_STALL7) chk({tag, " stall_cnt"}, stall_cnt_o, 7);
`endif

        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            ready_i = 1'b1;
            @(negedge clk);
            if (done_o || busy_o || valid_o || rden_o) post_bad++;
        end

        chk({tag, " done_count"}, dones, 1);
        chk({tag, " outputs"}, outs, exp_outs);
        chk({tag, " lasts"}, lasts, exp_lasts);
        chk({tag, " data_mismatches"}, data_bad, 0);
        chk({tag, " addr_mismatches"}, addr_bad, 0);
        chk({tag, " extra_reads"}, extra_rd, 0);
        chk({tag, " reads_missing"}, addr_q.size(), 0);
        chk({tag, " credit_violations"}, credit_bad, 0);
        chk({tag, " unstable_while_stalled"}, unstable, 0);
        chk({tag, " busy_errors"}, busy_bad, 0);
        chk({tag, " post_done_activity"}, post_bad, 0);
        if (exp_done >= 0) chk({tag, " done_cycle"}, done_cyc, exp_done);
        if (len == 0) begin
            chk({tag, " first_rden"}, first_rden, -1);
            chk({tag, " first_valid"}, first_valid, -1);
        end else if (mode == M_HI) begin
            chk({tag, " first_rden"}, first_rden, 1);
            chk({tag, " first_valid"}, first_valid, 3);
        end
    endtask

    vec_t vecs [9];

    initial begin
        int n, cyc, l, r;
        logic [31:0] outs_now;

        vecs[0] = '{4,    0,   M_HI,     1'b0, 4,    1,   7};
        vecs[1] = '{3,    2,   M_HI,     1'b0, 9,    3,   12};
        vecs[2] = '{8,    0,   M_TOG,    1'b0, 8,    1,   -1};
        vecs[3] = '{0,    0,   M_HI,     1'b0, 0,    0,   1};
        vecs[4] = '{1024, 1,   M_HI,     1'b0, 2048, 2,   2051};
        vecs[5] = '{1,    0,   M_HI,     1'b0, 1,    1,   4};
        vecs[6] = '{2,    255, M_HI,     1'b0, 512,  256, 515};
        vecs[7] = '{5,    1,   M_HI,     1'b1, 10,   2,   13};
        vecs[8] = '{4,    0,   M_STALL7, 1'b0, 4,    1,   14};

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
        mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h12; mem[3] = 8'h13;

        rst_n = 1'b0; start_i = 1'b0; len_i = '0; rpt_i = '0; ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {rden_o, rdptr_o, ifmap_o, valid_o, last_o, done_o, busy_o}, 0);
`ifdef FC_RD_STALL_CNT_EN
        chk("reset_stall_cnt", stall_cnt_o, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int v = 0; v < 9; v++)
            run_job($sformatf("vec%0d", v), vecs[v].len, vecs[v].rpt, vecs[v].mode,
                    vecs[v].hold, vecs[v].exp_outs, vecs[v].exp_lasts, vecs[v].exp_done);

        for (int j = 0; j < 12; j++) begin
            l = $urandom_range(1, 40);
            r = $urandom_range(0, 3);
            run_job($sformatf("rand%0d", j), l, r, M_RAND, 1'b0, l * (r + 1), r + 1, -1);
        end

        // Abort a job after five outputs, then confirm a fresh job is clean.
        @(posedge clk); #1;
        start_i = 1'b1; len_i = (ADDR_W+1)'(20); rpt_i = 8'd0; ready_i = 1'b1;
        n = 0; cyc = 0;
        while (n < 5 && cyc < 100) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            @(negedge clk);
            if (valid_o && ready_i) n++;
            cyc++;
        end
        chk("abort_outputs_before_reset", n, 5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        outs_now = 32'({rden_o, rdptr_o, ifmap_o, valid_o, last_o, done_o, busy_o});
        chk("abort_reset_outputs", outs_now, 0);
`ifdef FC_RD_STALL_CNT_EN
        chk("abort_reset_stall_cnt", stall_cnt_o, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem[0] = 8'hA0; mem[1] = 8'hA1;
        run_job("after_abort", 2, 0, M_HI, 1'b0, 2, 1, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fc_ifmap_rd_ctrl.md
Name: fc_ifmap_rd_ctrl

Overview:
- Read-side sequencer for the FC ifmap buffer. It drives the buffer read port (rden/rdptr) and accepts read data one cycle later.
- Streams bytes to the FC PE array over a valid/ready interface.
- Replays the stored vector a programmable number of times, one pass per output-neuron group.
- Pairs with the write side, which fills the buffer through wren/wrptr/ifmap data.

Parameters:
ADDR_W, 10, buffer address width (depth 2**ADDR_W)
DATA_W, 8, ifmap element width

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
start_i  input  1  start request; sampled only in IDLE
len_i  input  ADDR_W+1  vector length, 0..1024; latched on start
rpt_i  input  8  extra passes; total passes = rpt_i+1; latched on start
rden_o  output  1  buffer read enable
rdptr_o  output  ADDR_W  buffer read address
ifmap_i  input  DATA_W  buffer read data, valid the cycle after rden_o
ifmap_o  output  DATA_W  stream data
valid_o  output  1  stream valid
ready_i  input  1  stream ready
last_o  output  1  marks final element of each pass; qualified by valid_o
done_o  output  1  one-cycle pulse when the job completes
busy_o  output  1  high from start acceptance until done_o

Behaviour:
- Reset: on posedge clk with rst_n=0, all outputs go to 0, the FSM goes to IDLE, and skid-buffer contents and in-flight reads are discarded. This applies mid-job as well; no done_o is produced for an aborted job.
- FSM states are IDLE, RUN and FIN.
- IDLE:
  - start_i=1 with len_i!=0: latch len/rpt, clear the element index and pass counter, set busy_o=1, go to RUN.
  - start_i=1 with len_i=0: go to FIN with no read issued.
  - start_i while not in IDLE is ignored.
- RUN, read issue:
  - Skid buffer is a 2-entry FIFO (count 0..2). inflight = rden_o of the previous cycle.
  - Issue rden_o=1 when reads remain AND (count - pop + inflight) < 2, where pop = valid_o & ready_i this cycle.
  - This rule guarantees no overflow and sustains 1 element/cycle when ready_i is held high.
- Read address sequence:
  - Addresses run 0..len-1, then wrap to 0 for the next pass.
  - Total reads issued = len*(rpt+1).
  - rdptr_o holds its last value when rden_o=0.
- Data path:
  - ifmap_i is pushed into the FIFO on the cycle after rden_o.
  - valid_o = (count != 0); ifmap_o is the FIFO head, registered.
  - Order is preserved; no element is dropped or duplicated under any ready_i pattern.
- Latency: start sampled in cycle 0 → rden_o=1, rdptr_o=0 in cycle 1 → data captured at the end of cycle 2 → valid_o=1 in cycle 3.
- Stream rules:
  - valid_o, once high, stays high with ifmap_o and last_o stable until the handshake completes.
  - last_o travels with the element whose index is len-1 in each pass, so it is high rpt+1 times per job.
- Completion:
  - After the handshake of the final element of the final pass, go to FIN.
  - FIN lasts one cycle with done_o=1, then returns to IDLE with busy_o=0.
  - A start_i in that FIN cycle is ignored.
  - For len=0, done_o is high in cycle 1 and busy_o stays 0.
- Widths:
  - The element index is ADDR_W+1 bits so len=1024 is reachable; the address wraps from 1023 to 0.
  - The pass counter is 8 bits and compares against rpt; a value of 255 gives 256 passes.

Optional Feature:
FC_RD_STALL_CNT_EN:
- Defined: adds output stall_cnt_o[15:0].
  - Counts cycles with valid_o=1 and ready_i=0 during the current job, saturating at 16'hFFFF.
  - Cleared on start acceptance and on reset; holds its value after done_o.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Buffer preloaded 0x10,0x11,0x12,0x13; len=4, rpt=0, ready_i=1 → rdptr_o 0,1,2,3 in cycles 1-4; valid_o cycles 3-6 carrying 0x10..0x13; last_o in cycle 6; done_o in cycle 7.
- len=3, rpt=2, ready high → rdptr_o 0,1,2,0,1,2,0,1,2; 9 outputs; last_o on outputs 3, 6 and 9; exactly one done_o.
- len=8, ready_i toggling 1-0 with random stalls → output sequence equals buffer[0..7]; data held stable while stalled; rden_o never issued when the credit rule is false.
- len=0 start → done_o in cycle 1; no rden_o ever; valid_o stays 0.
- len=1024, rpt=1 → rdptr_o runs 1023 then 0; 2048 outputs; last_o twice.
- Reset asserted mid-RUN after 5 outputs → all outputs 0 the next cycle; a new start with len=2 produces only the new data.
- With FC_RD_STALL_CNT_EN: len=4 with ready_i held low for 7 cycles while valid_o is high → stall_cnt_o=7 at done_o.
